// File: rtl/axi4s_uart_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_uart_if
// Brief    : AXI4-Stream byte channel (tvalid/tready/tdata) for the UART.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4s_uart_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/axi4s_uart.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_uart
// Brief    : Full-duplex 8N1 UART bridging a serial line and AXI4-Stream bytes.
//            Optional even parity when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module axi4s_uart #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  wire            aclk,
    input  wire            areset,
    input  wire            uart_rxd,
    output logic           uart_txd,
    axi4s_uart_if.master   rx_byte,
    axi4s_uart_if.slave    tx_byte,
    output logic           rx_frame_err,
`ifdef UART_PARITY_EN
    output logic           rx_parity_err,
`endif
    output logic           rx_overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_bit_reload  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_reload = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_baud_check
            $error("axi4s_uart: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ------------------------------------------------------------------ RX
    logic             r_rxd_s1, r_rxd_s2, r_rxd_s3;
    state_t           r_rx_state, w_rx_state_d;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_d;
    logic [2:0]       r_rx_bit, w_rx_bit_d;
    logic [7:0]       r_rx_shift, w_rx_shift_d;
    logic             w_rx_fall, w_rx_tick;
    logic             w_rx_done, w_frame_err, w_parity_err;
    logic             r_rx_valid;
    logic [7:0]       r_rx_data;
    logic             r_frame_err, r_overrun, r_parity_err;

    // Third flop only remembers the previous synchronized level for edge detect
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_s3 <= 1'b1;
        end else begin
            r_rxd_s1 <= uart_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_s3 <= r_rxd_s2;
        end
    end

    assign w_rx_fall = r_rxd_s3 & ~r_rxd_s2;
    assign w_rx_tick = (r_rx_cnt == '0);

    always_comb begin
        w_rx_state_d = r_rx_state;
        w_rx_cnt_d   = r_rx_cnt;
        w_rx_bit_d   = r_rx_bit;
        w_rx_shift_d = r_rx_shift;
        w_rx_done    = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_cnt_d   = c_half_reload;
                    w_rx_state_d = S_START;
                end
            end
            S_START: begin
                if (!w_rx_tick) begin
                    w_rx_cnt_d = r_rx_cnt - c_cnt_one;
                end else if (r_rxd_s2) begin
                    w_rx_state_d = S_IDLE;
                end else begin
                    w_rx_cnt_d   = c_bit_reload;
                    w_rx_bit_d   = 3'd0;
                    w_rx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!w_rx_tick) begin
                    w_rx_cnt_d = r_rx_cnt - c_cnt_one;
                end else begin
                    w_rx_shift_d = {r_rxd_s2, r_rx_shift[7:1]};
                    w_rx_cnt_d   = c_bit_reload;
                    w_rx_bit_d   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_rx_state_d = S_PARITY;
`else
                        w_rx_state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (!w_rx_tick) begin
                    w_rx_cnt_d = r_rx_cnt - c_cnt_one;
                end else begin
                    w_rx_cnt_d = c_bit_reload;
                    if (r_rxd_s2 != ^r_rx_shift) begin
                        w_parity_err = 1'b1;
                        w_rx_state_d = S_IDLE;
                    end else begin
                        w_rx_state_d = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (!w_rx_tick) begin
                    w_rx_cnt_d = r_rx_cnt - c_cnt_one;
                end else begin
                    w_rx_state_d = S_IDLE;
                    w_rx_done    = r_rxd_s2;
                    w_frame_err  = ~r_rxd_s2;
                end
            end
            default: w_rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_d;
            r_rx_cnt   <= w_rx_cnt_d;
            r_rx_bit   <= w_rx_bit_d;
            r_rx_shift <= w_rx_shift_d;
        end
    end

    // Single-entry output register; a completed byte may refill it in the same
    // cycle the consumer drains it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
            r_overrun    <= w_rx_done && r_rx_valid && !rx_byte.tready;
            if (w_rx_done && (!r_rx_valid || rx_byte.tready)) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_rx_shift_d;
            end else if (rx_byte.tready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_byte.tvalid = r_rx_valid;
    assign rx_byte.tdata  = r_rx_data;
    assign rx_frame_err   = r_frame_err;
    assign rx_overrun     = r_overrun;
`ifdef UART_PARITY_EN
    assign rx_parity_err  = r_parity_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = r_parity_err;
`endif

    // ------------------------------------------------------------------ TX
    state_t           r_tx_state, w_tx_state_d;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]       r_tx_bit, w_tx_bit_d;
    logic [7:0]       r_tx_shift, w_tx_shift_d;
    logic             r_tx_par, w_tx_par_d;
    logic             r_txd, w_txd_d;
    logic             w_tx_ready, w_tx_tick;

    assign w_tx_ready     = (r_tx_state == S_IDLE) && !areset;
    assign w_tx_tick      = (r_tx_cnt == '0);
    assign tx_byte.tready = w_tx_ready;

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        w_tx_par_d   = r_tx_par;
        case (r_tx_state)
            S_IDLE: begin
                if (tx_byte.tvalid && w_tx_ready) begin
                    w_tx_shift_d = tx_byte.tdata;
                    w_tx_par_d   = ^tx_byte.tdata;
                    w_tx_cnt_d   = c_bit_reload;
                    w_tx_state_d = S_START;
                end
            end
            S_START: begin
                if (!w_tx_tick) begin
                    w_tx_cnt_d = r_tx_cnt - c_cnt_one;
                end else begin
                    w_tx_cnt_d   = c_bit_reload;
                    w_tx_bit_d   = 3'd0;
                    w_tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!w_tx_tick) begin
                    w_tx_cnt_d = r_tx_cnt - c_cnt_one;
                end else begin
                    w_tx_cnt_d = c_bit_reload;
                    if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_tx_state_d = S_PARITY;
`else
                        w_tx_state_d = S_STOP;
`endif
                    end else begin
                        w_tx_bit_d   = r_tx_bit + 3'd1;
                        w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (!w_tx_tick) begin
                    w_tx_cnt_d = r_tx_cnt - c_cnt_one;
                end else begin
                    w_tx_cnt_d   = c_bit_reload;
                    w_tx_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!w_tx_tick) begin
                    w_tx_cnt_d = r_tx_cnt - c_cnt_one;
                end else begin
                    w_tx_state_d = S_IDLE;
                end
            end
            default: w_tx_state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so uart_txd is a clean flop
        case (w_tx_state_d)
            S_START:  w_txd_d = 1'b0;
            S_DATA:   w_txd_d = w_tx_shift_d[0];
`ifdef UART_PARITY_EN
            S_PARITY: w_txd_d = w_tx_par_d;
`endif
            default:  w_txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_tx_par   <= w_tx_par_d;
            r_txd      <= w_txd_d;
        end
    end

    assign uart_txd = r_txd;

endmodule
`default_nettype wire
